icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
Direct-mapped, one-word-per-line instruction cache controller.
- Sits between the processor's fetch port (pc_addr / instruction) and the tagged unified memory model.
- Serves hits combinationally. On a miss, issues one BUS_LOAD, tracks the returned transaction tag and fills the line.
- Shields the IF stage from memory latency; the IF stage stalls while Icache_valid_out is low.

Parameters:
NUM_LINES, 32, number of cache lines; power of two, at least 2; IDX = log2(NUM_LINES)
BUS_NONE, 2'd0, memory command encoding for idle
BUS_LOAD, 2'd1, memory command encoding for a read

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
proc2Icache_addr  input  32  fetch address from IF stage; bits [1:0] ignored
Icache_data_out  output  32  instruction word for proc2Icache_addr; valid only when Icache_valid_out=1
Icache_valid_out  output  1  combinational hit indication for the current address
proc2mem_addr  output  32  memory request address, word aligned ({addr[31:2],2'b00})
proc2mem_command  output  2  BUS_NONE or BUS_LOAD
mem2proc_response  input  4  nonzero transaction tag when memory accepts the request this cycle; 0 means rejected
mem2proc_data  input  32  returned read data
mem2proc_tag  input  4  tag of the data on mem2proc_data; 0 means no data

Behaviour:
- Address split:
  - index = addr[IDX+1:2]
  - line tag = addr[31:IDX+2]
- Storage per line: valid bit, tag, 32-bit data. The data array needs no reset.
- Hit (same-cycle lookup):
  - hit = valid[index] && tag[index] == line tag.
  - Icache_valid_out = hit, combinational.
  - Icache_data_out = data[index]; don't-care on a miss.
- States: IDLE, WAIT.
- IDLE:
  - On a miss, drive proc2mem_command=BUS_LOAD and proc2mem_addr=word-aligned proc2Icache_addr in the same cycle. Otherwise drive BUS_NONE and proc2mem_addr=0.
  - Miss with mem2proc_response != 0: at the edge, latch pend_tag=response, pend_idx and pend_linetag from the current address; go to WAIT.
  - Miss with mem2proc_response == 0: stay in IDLE; the request is re-issued next cycle.
- WAIT:
  - Drive proc2mem_command=BUS_NONE.
  - When mem2proc_tag == pend_tag (pend_tag is never 0): at the edge, write data[pend_idx]=mem2proc_data, tag[pend_idx]=pend_linetag, valid[pend_idx]=1; clear pend_tag; go to IDLE.
- Fill-to-hit latency:
  - The filled line is first visible as a hit the cycle after the matching tag arrives.
  - No same-cycle forwarding of mem2proc_data.
- Address changes during WAIT (branch redirect):
  - Lookups continue on the new address; hits are served normally.
  - The outstanding fill still completes into pend_idx.
  - No new request is issued until the controller is back in IDLE.
- Simultaneous fill and lookup of the same index: the lookup sees the pre-fill contents that cycle.
- mem2proc_tag == 0, or a tag not equal to pend_tag, is ignored in every state.
- Conflict miss: a fill overwrites the line unconditionally.
- Reset values (asynchronous):
  - All valid bits 0; state IDLE; pend_tag 0; proc2mem_command BUS_NONE.
  - Icache_valid_out 0 (follows from valid=0).
- Reset mid-miss: the pending transaction is dropped. A later response carrying its tag is ignored because pend_tag=0.
- Only one outstanding miss at a time.

Optional Feature:
ICACHE_STATS_EN
- Compiled in:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on every cycle with Icache_valid_out=1.
  - miss_count increments once per accepted BUS_LOAD (IDLE, miss, response != 0).
  - Counters wrap at 2^32.
- Compiled out: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Cold miss: after reset, addr=0x100 (index 0, tag 2); memory accepts with response=3 and returns tag 3 with data 0x00500093 N cycles later -> one BUS_LOAD to 0x100; valid_out=0 until the cycle after tag 3 arrives, then valid_out=1, data=0x00500093.
2. Hit: re-present 0x100 -> valid_out=1 the same cycle, proc2mem_command=BUS_NONE.
3. Rejected request: miss with response=0 for 3 cycles, then 5 -> BUS_LOAD asserted on 4 consecutive cycles; exactly one fill, tracked with tag 5.
4. Conflict and redirect: fill 0x100, then miss on 0x180 (index 0, tag 3); switch addr back to 0x104 while in WAIT -> 0x104 misses but issues no request until the 0x180 fill lands; after the fill, 0x100 misses and 0x180 hits.
5. Stray and mid-miss reset: assert rst while in WAIT with pend_tag=7; after release, memory returns tag 7 -> no line written; valid_out=0 for 0x100; state IDLE.
6. ICACHE_STATS_EN: sequence of scenarios 1 and 2 -> miss_count=1, and hit_count equals the number of hit cycles.

Source files
------------

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signal bundle for icache_ctrl.
// slave : the cache controller
// master: whatever drives fetch addresses and models memory
interface icache_ctrl_if;
    logic [31:0] proc2Icache_addr;
    logic [31:0] Icache_data_out;
    logic        Icache_valid_out;
    logic [31:0] proc2mem_addr;
    logic [1:0]  proc2mem_command;
    logic [3:0]  mem2proc_response;
    logic [31:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    modport slave (
        input  proc2Icache_addr, mem2proc_response, mem2proc_data, mem2proc_tag,
        output Icache_data_out, Icache_valid_out, proc2mem_addr, proc2mem_command
    );

    modport master (
        output proc2Icache_addr, mem2proc_response, mem2proc_data, mem2proc_tag,
        input  Icache_data_out, Icache_valid_out, proc2mem_addr, proc2mem_command
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache controller.
// Hits are served combinationally; a miss issues one BUS_LOAD, tracks the
// returned transaction tag and fills the line. One miss outstanding at most.
// Optional: define ICACHE_STATS_EN to add hit_count / miss_count outputs.

// One cache line: valid bit (reset), tag and data (no reset needed).
module icache_line #(
    parameter int TAG_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [31:0]      data
);
    // valid goes high on the first fill and stays until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        valid <= 1'b0;
        else if (wr_en) valid <= 1'b1;
    end

    // tag/data are qualified by valid, so they are left unreset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag  <= wr_tag;
            data <= wr_data;
        end
    end
endmodule

module icache_ctrl #(
    parameter int         NUM_LINES = 32,
    parameter logic [1:0] BUS_NONE  = 2'd0,
    parameter logic [1:0] BUS_LOAD  = 2'd1
) (
    input  logic        clk,
    input  logic        rst,
    icache_ctrl_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - IDX - 2;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
    } mem_req_t;

    state_t                   state, state_nx;
    mem_req_t                 req;
    logic [3:0]               pend_tag;
    logic [IDX-1:0]           pend_idx;
    logic [TAG_W-1:0]         pend_linetag;
    logic                     accept, fill, hit;

    logic [IDX-1:0]           cur_idx;
    logic [TAG_W-1:0]         cur_tag;

    logic [NUM_LINES-1:0]             line_valid;
    logic [NUM_LINES-1:0][TAG_W-1:0]  line_tag;
    logic [NUM_LINES-1:0][31:0]       line_data;
    logic [NUM_LINES-1:0]             fill_sel;

    // word-offset bits never take part in lookup or requests
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.proc2Icache_addr[1:0];

    assign cur_idx = bus.proc2Icache_addr[IDX+1:2];
    assign cur_tag = bus.proc2Icache_addr[31:IDX+2];

    // one-hot write enable for the line being filled
    assign fill_sel = fill ? (NUM_LINES'(1) << pend_idx) : '0;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        icache_line #(.TAG_W(TAG_W)) u_line (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (fill_sel[i]),
            .wr_tag  (pend_linetag),
            .wr_data (bus.mem2proc_data),
            .valid   (line_valid[i]),
            .tag     (line_tag[i]),
            .data    (line_data[i])
        );
    end

    // same-cycle lookup; a fill landing this cycle is not forwarded
    assign hit = line_valid[cur_idx] && (line_tag[cur_idx] == cur_tag);

    assign bus.Icache_valid_out = hit;
    assign bus.Icache_data_out  = line_data[cur_idx];
    assign bus.proc2mem_command = req.cmd;
    assign bus.proc2mem_addr    = req.addr;

    // next state and memory request; requests are only raised from IDLE
    always_comb begin
        state_nx = state;
        req      = '0;
        req.cmd  = BUS_NONE;
        accept   = 1'b0;
        fill     = 1'b0;
        case (state)
            IDLE: begin
                if (!hit && !rst) begin
                    req.cmd  = BUS_LOAD;
                    req.addr = {bus.proc2Icache_addr[31:2], 2'b00};
                    if (bus.mem2proc_response != 4'd0) begin
                        accept   = 1'b1;
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (pend_tag != 4'd0 && bus.mem2proc_tag == pend_tag) begin
                    fill     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // pending-miss bookkeeping; cleared tag makes late responses harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_tag     <= 4'd0;
            pend_idx     <= '0;
            pend_linetag <= '0;
        end else if (accept) begin
            pend_tag     <= bus.mem2proc_response;
            pend_idx     <= cur_idx;
            pend_linetag <= cur_tag;
        end else if (fill) begin
            pend_tag     <= 4'd0;
        end
    end

`ifdef ICACHE_STATS_EN
    // free-running hit/miss counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (hit)    hit_count  <= hit_count + 32'd1;
            if (accept) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios followed by randomized traffic,
// checked every cycle against a line-map reference model.
module tb_icache_ctrl;
    localparam int NL = 32;

    logic clk;
    logic rst;
    icache_ctrl_if bus();
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_ctrl #(.NUM_LINES(NL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int dut_loads = 0;

    // reference model: each line remembers the word address it holds
    bit          m_vld   [NL];
    logic [29:0] m_waddr [NL];
    logic [31:0] m_data  [NL];
    bit          m_pend;
    logic [3:0]  m_ptag;
    logic [29:0] m_paddr;
    int unsigned m_hits, m_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive, compare pre-edge outputs, then advance the model
    task automatic cyc(input logic r, input logic [31:0] a, input logic [3:0] resp,
                       input logic [3:0] mt, input logic [31:0] md);
        int          idx;
        bit          eh;
        logic [1:0]  ec;
        logic [31:0] ea;
        bit          was_pend;
        @(negedge clk);
        rst = r;
        bus.proc2Icache_addr  = a;
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = mt;
        bus.mem2proc_data     = md;
        #1;
        idx = int'(a[31:2] % NL);
        eh  = !r && m_vld[idx] && (m_waddr[idx] == a[31:2]);
        ec  = (!r && !m_pend && !eh) ? 2'd1 : 2'd0;
        ea  = (ec == 2'd1) ? {a[31:2], 2'b00} : 32'd0;
        chk("valid_out", {31'd0, bus.Icache_valid_out}, {31'd0, eh});
        if (eh) chk("data_out", bus.Icache_data_out, m_data[idx]);
        chk("mem_cmd", {30'd0, bus.proc2mem_command}, {30'd0, ec});
        chk("mem_addr", bus.proc2mem_addr, ea);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_miss);
`endif
        if (bus.proc2mem_command == 2'd1) dut_loads++;
        if (r) begin
            for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
            m_pend = 1'b0;
            m_ptag = 4'd0;
            m_hits = 0;
            m_miss = 0;
        end else begin
            was_pend = m_pend;
            if (was_pend && mt == m_ptag) begin
                m_vld[int'(m_paddr % NL)]   = 1'b1;
                m_waddr[int'(m_paddr % NL)] = m_paddr;
                m_data[int'(m_paddr % NL)]  = md;
                m_pend = 1'b0;
                m_ptag = 4'd0;
            end
            if (!was_pend && !eh && resp != 4'd0) begin
                m_pend  = 1'b1;
                m_ptag  = resp;
                m_paddr = a[31:2];
                m_miss++;
            end
            if (eh) m_hits++;
        end
    endtask

    initial begin
        int          base;
        int          ret_cnt;
        int          sel;
        bit          was_pend;
        bit          eh;
        logic [31:0] a, hi;
        logic [3:0]  resp, mt;
        logic        r;

        rst = 1'b1;
        bus.proc2Icache_addr  = 32'h100;
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag      = 4'd0;
        bus.mem2proc_data     = 32'd0;
        m_pend = 1'b0; m_ptag = 4'd0; m_paddr = '0; m_hits = 0; m_miss = 0;
        for (int i = 0; i < NL; i++) begin
            m_vld[i] = 1'b0; m_waddr[i] = '0; m_data[i] = '0;
        end

        // reset state
        cyc(1, 32'h100, 4'd0, 4'd0, 32'd0);
        cyc(1, 32'h100, 4'd3, 4'd3, 32'd0);
        chk("rst_valid", {31'd0, bus.Icache_valid_out}, 32'd0);
        chk("rst_cmd", {30'd0, bus.proc2mem_command}, 32'd0);

        // cold miss, accepted with tag 3, data back three cycles later
        base = dut_loads;
        cyc(0, 32'h100, 4'd3, 4'd0, $urandom);
        cyc(0, 32'h100, 4'd0, 4'd0, $urandom);
        cyc(0, 32'h100, 4'd0, 4'd9, $urandom);
        cyc(0, 32'h100, 4'd0, 4'd3, 32'h0050_0093);
        chk("tp1_miss_on_fill", {31'd0, bus.Icache_valid_out}, 32'd0);
        cyc(0, 32'h100, 4'd0, 4'd0, $urandom);
        chk("tp1_hit", {31'd0, bus.Icache_valid_out}, 32'd1);
        chk("tp1_data", bus.Icache_data_out, 32'h0050_0093);
        chk("tp1_loads", dut_loads - base, 32'd1);

        // hit again, no request
        cyc(0, 32'h101, 4'd4, 4'd0, $urandom);
        chk("tp2_hit", {31'd0, bus.Icache_valid_out}, 32'd1);
        chk("tp2_cmd", {30'd0, bus.proc2mem_command}, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("tp6_miss", miss_count, 32'd1);
        chk("tp6_hit", hit_count, 32'd1);
`endif

        // rejected three times, accepted with tag 5
        base = dut_loads;
        cyc(0, 32'h204, 4'd0, 4'd0, $urandom);
        cyc(0, 32'h204, 4'd0, 4'd0, $urandom);
        cyc(0, 32'h204, 4'd0, 4'd0, $urandom);
        cyc(0, 32'h204, 4'd5, 4'd0, $urandom);
        cyc(0, 32'h204, 4'd0, 4'd5, 32'hCAFE_0204);
        cyc(0, 32'h204, 4'd0, 4'd5, $urandom);
        chk("tp3_loads", dut_loads - base, 32'd4);
        chk("tp3_data", bus.Icache_data_out, 32'hCAFE_0204);

        // conflict miss on index 0 plus redirect while waiting
        cyc(0, 32'h180, 4'd6, 4'd0, $urandom);
        base = dut_loads;
        cyc(0, 32'h104, 4'd9, 4'd0, $urandom);
        cyc(0, 32'h100, 4'd0, 4'd2, $urandom);
        chk("tp4_old_hit", {31'd0, bus.Icache_valid_out}, 32'd1);
        cyc(0, 32'h104, 4'd0, 4'd6, 32'h1234_0180);
        chk("tp4_no_req", dut_loads - base, 32'd0);
        cyc(0, 32'h104, 4'd0, 4'd0, $urandom);
        chk("tp4_req_after", {30'd0, bus.proc2mem_command}, 32'd1);
        cyc(0, 32'h100, 4'd0, 4'd0, $urandom);
        chk("tp4_evicted", {31'd0, bus.Icache_valid_out}, 32'd0);
        cyc(0, 32'h180, 4'd0, 4'd0, $urandom);
        chk("tp4_new_hit", bus.Icache_data_out, 32'h1234_0180);

        // reset in WAIT, stale tag 7 arrives afterwards
        cyc(0, 32'h300, 4'd7, 4'd0, $urandom);
        cyc(0, 32'h300, 4'd0, 4'd0, $urandom);
        cyc(1, 32'h300, 4'd0, 4'd0, $urandom);
        cyc(0, 32'h100, 4'd0, 4'd7, $urandom);
        chk("tp5_valid", {31'd0, bus.Icache_valid_out}, 32'd0);
        chk("tp5_idle_req", {30'd0, bus.proc2mem_command}, 32'd1);
        cyc(0, 32'h300, 4'd0, 4'd0, $urandom);
        chk("tp5_nofill", {31'd0, bus.Icache_valid_out}, 32'd0);

        // randomized traffic: small address pool for hits and conflicts
        ret_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 4);
            hi  = (sel == 4) ? 32'h01FF_FFFF : 32'(sel);
            a   = (hi << 7) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            eh  = m_vld[int'(a[31:2] % NL)] && (m_waddr[int'(a[31:2] % NL)] == a[31:2]);
            if (!m_pend && !eh)
                resp = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            else
                resp = 4'($urandom_range(0, 15));
            if (m_pend && ret_cnt == 0) mt = m_ptag;
            else mt = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if (m_pend && ret_cnt > 0) ret_cnt--;
            was_pend = m_pend;
            cyc(r, a, resp, mt, $urandom);
            if (m_pend && !was_pend) ret_cnt = $urandom_range(0, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
